// File: rtl/m2_block_scheduler_pkg.sv
// Shared types and constants for the milestone 2 block scheduler:
// FSM states, segment codes, engine bit positions, block counts and SRAM offsets.
package m2_block_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_F,
        S_LEAD_CT,
        S_MEGA_A,
        S_MEGA_B,
        S_OUT_CS,
        S_OUT_W,
        S_FINISH
    } m2_sched_state_type;

    localparam logic [1:0] SEG_Y = 2'd0;
    localparam logic [1:0] SEG_U = 2'd1;
    localparam logic [1:0] SEG_V = 2'd2;

    // Engine bit positions in the 4-bit start/done vectors: {fetch, ct, cs, ws}
    localparam logic [3:0] ENG_F  = 4'b1000;
    localparam logic [3:0] ENG_CT = 4'b0100;
    localparam logic [3:0] ENG_CS = 4'b0010;
    localparam logic [3:0] ENG_W  = 4'b0001;

    localparam logic [11:0] Y_BLOCKS     = 12'd1200;
    localparam logic [11:0] UV_BLOCKS    = 12'd600;
    localparam logic [11:0] TOTAL_BLOCKS = Y_BLOCKS + UV_BLOCKS + UV_BLOCKS;

    localparam logic [5:0] Y_BLK_COLS  = 6'd40;
    localparam logic [5:0] UV_BLK_COLS = 6'd20;
    localparam logic [4:0] BLK_ROWS    = 5'd30;

    localparam logic [17:0] PRE_IDCT_OFFSET = 18'd76800;
    localparam logic [17:0] U_OFFSET        = 18'd38400;
    localparam logic [17:0] V_OFFSET        = 18'd57600;

    // Coefficient regions: Y occupies 76800 words, U 38400 words, then V
    localparam logic [17:0] FETCH_U_OFFSET = PRE_IDCT_OFFSET + 18'd76800;
    localparam logic [17:0] FETCH_V_OFFSET = PRE_IDCT_OFFSET + 18'd115200;

endpackage

// File: rtl/m2_block_addr_gen.sv
// One (seg, brow, bcol) block tracker with its SRAM base-address calculation.
// Fetch mode addresses coefficient blocks, write mode addresses pixel-pair blocks.
module m2_block_addr_gen
    import m2_block_scheduler_pkg::*;
#(
    parameter bit WRITE_MODE = 1'b0
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        issue,
    output logic [17:0] base,
    output logic [1:0]  seg
);

    logic [1:0]  cur_seg;
    logic [4:0]  cur_brow;
    logic [5:0]  cur_bcol;
    logic [5:0]  last_col;
    logic [17:0] brow_ext;
    logic [17:0] bcol_ext;
    logic [17:0] row_term;
    logic [17:0] col_term;
    logic [17:0] seg_offset;
    logic [17:0] calc_base;

    // Row strides: fetch Y 2560, fetch U/V 1280, write Y 1280, write U/V 640
    always_comb begin
        brow_ext   = {13'd0, cur_brow};
        bcol_ext   = {12'd0, cur_bcol};
        last_col   = (cur_seg == SEG_Y) ? (Y_BLK_COLS - 6'd1) : (UV_BLK_COLS - 6'd1);
        row_term   = '0;
        col_term   = '0;
        seg_offset = '0;
        if (WRITE_MODE) begin
            col_term = bcol_ext << 2;
            if (cur_seg == SEG_Y) begin
                row_term   = (brow_ext << 10) + (brow_ext << 8);
                seg_offset = '0;
            end else begin
                row_term   = (brow_ext << 9) + (brow_ext << 7);
                seg_offset = (cur_seg == SEG_U) ? U_OFFSET : V_OFFSET;
            end
        end else begin
            col_term = bcol_ext << 3;
            if (cur_seg == SEG_Y) begin
                row_term   = (brow_ext << 11) + (brow_ext << 9);
                seg_offset = PRE_IDCT_OFFSET;
            end else begin
                row_term   = (brow_ext << 10) + (brow_ext << 8);
                seg_offset = (cur_seg == SEG_U) ? FETCH_U_OFFSET : FETCH_V_OFFSET;
            end
        end
        calc_base = seg_offset + row_term + col_term;
    end

    // After the last V block the tracker wraps back to (Y, 0, 0) for the next frame
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            cur_seg  <= SEG_Y;
            cur_brow <= '0;
            cur_bcol <= '0;
            base     <= '0;
            seg      <= '0;
        end else if (issue) begin
            base <= calc_base;
            seg  <= cur_seg;
            if (cur_bcol == last_col) begin
                cur_bcol <= '0;
                if (cur_brow == BLK_ROWS - 5'd1) begin
                    cur_brow <= '0;
                    cur_seg  <= (cur_seg == SEG_V) ? SEG_Y : cur_seg + 2'd1;
                end else begin
                    cur_brow <= cur_brow + 5'd1;
                end
            end else begin
                cur_bcol <= cur_bcol + 6'd1;
            end
        end
    end

endmodule

// File: rtl/m2_block_scheduler.sv
// Milestone 2 top sequencer: walks all Y, U and V blocks through the
// Fetch S' / Compute T / Compute S / Write S engines in a two-phase overlap.
module m2_block_scheduler
    import m2_block_scheduler_pkg::*;
(
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        m2_start,
    output logic        m2_finish,
    output logic        busy,
    output logic        fetch_start,
    input  logic        fetch_done,
    output logic [17:0] fetch_base,
    output logic [1:0]  fetch_seg,
    output logic        ct_start,
    input  logic        ct_done,
    output logic        cs_start,
    input  logic        cs_done,
    output logic        ws_start,
    input  logic        ws_done,
    output logic [17:0] write_base,
    output logic [1:0]  write_seg
);

    m2_sched_state_type state, next_state;

    logic [11:0] blk_cnt;
    logic        blk_inc;
    logic        finish_issue;
    logic        finish_q;
    logic        busy_q;
    logic [3:0]  issue_vec;
    logic [3:0]  start_q;
    logic [3:0]  done_vec;
    logic [3:0]  pend_vec;
    logic [3:0]  flag_vec;
    logic [3:0]  accept_vec;
    logic [3:0]  ok_vec;
    logic [3:0]  req_vec;
    logic        phase_done;

    // Handshake: each *_start is a one-cycle registered pulse that makes the engine
    // outstanding; the engine answers with *_done at least one cycle later. A done
    // for an outstanding engine sets a sticky flag that lives until the next phase
    // issues; a done for an engine with nothing outstanding is dropped.
    assign done_vec   = {fetch_done, ct_done, cs_done, ws_done};
    assign accept_vec = done_vec & pend_vec & ~start_q;
    assign ok_vec     = flag_vec | accept_vec;
    assign phase_done = ((ok_vec & req_vec) == req_vec);

    assign fetch_start = start_q[3];
    assign ct_start    = start_q[2];
    assign cs_start    = start_q[1];
    assign ws_start    = start_q[0];
    assign m2_finish   = finish_q;
    assign busy        = busy_q;

    always_comb begin
        req_vec = '0;
        case (state)
            S_LEAD_F:  req_vec = ENG_F;
            S_LEAD_CT: req_vec = ENG_CT;
            S_MEGA_A:  req_vec = ENG_CS | ENG_F;
            S_MEGA_B:  req_vec = ENG_CT | ENG_W;
            S_OUT_CS:  req_vec = ENG_CS;
            S_OUT_W:   req_vec = ENG_W;
            default:   req_vec = '0;
        endcase
    end

    always_comb begin
        next_state   = state;
        issue_vec    = '0;
        finish_issue = 1'b0;
        blk_inc      = 1'b0;
        case (state)
            S_IDLE: begin
                if (m2_start) begin
                    next_state = S_LEAD_F;
                    issue_vec  = ENG_F;
                end
            end
            S_LEAD_F: begin
                if (phase_done) begin
                    next_state = S_LEAD_CT;
                    issue_vec  = ENG_CT;
                end
            end
            S_LEAD_CT: begin
                if (phase_done) begin
                    next_state = S_MEGA_A;
                    issue_vec  = ENG_CS | ENG_F;
                end
            end
            S_MEGA_A: begin
                if (phase_done) begin
                    next_state = S_MEGA_B;
                    issue_vec  = ENG_CT | ENG_W;
                end
            end
            S_MEGA_B: begin
                // blk_cnt still holds b here; the block after b+1 must exist to fetch it
                if (phase_done) begin
                    blk_inc = 1'b1;
                    if (blk_cnt < TOTAL_BLOCKS - 12'd2) begin
                        next_state = S_MEGA_A;
                        issue_vec  = ENG_CS | ENG_F;
                    end else begin
                        next_state = S_OUT_CS;
                        issue_vec  = ENG_CS;
                    end
                end
            end
            S_OUT_CS: begin
                if (phase_done) begin
                    next_state = S_OUT_W;
                    issue_vec  = ENG_W;
                end
            end
            S_OUT_W: begin
                if (phase_done) begin
                    next_state   = S_FINISH;
                    finish_issue = 1'b1;
                end
            end
            S_FINISH: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            start_q  <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= next_state;
            start_q  <= issue_vec;
            finish_q <= finish_issue;
            busy_q   <= (next_state != S_IDLE);
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            blk_cnt <= '0;
        end else if (state == S_IDLE) begin
            blk_cnt <= '0;
        end else if (blk_inc) begin
            blk_cnt <= blk_cnt + 12'd1;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            pend_vec <= '0;
            flag_vec <= '0;
        end else begin
            pend_vec <= (pend_vec & ~accept_vec) | issue_vec;
            flag_vec <= (|issue_vec) ? 4'b0000 : (flag_vec | accept_vec);
        end
    end

    m2_block_addr_gen #(
        .WRITE_MODE (1'b0)
    ) u_fetch_addr (
        .CLOCK_50_I (CLOCK_50_I),
        .Resetn     (Resetn),
        .issue      (issue_vec[3]),
        .base       (fetch_base),
        .seg        (fetch_seg)
    );

    m2_block_addr_gen #(
        .WRITE_MODE (1'b1)
    ) u_write_addr (
        .CLOCK_50_I (CLOCK_50_I),
        .Resetn     (Resetn),
        .issue      (issue_vec[0]),
        .base       (write_base),
        .seg        (write_seg)
    );

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Bench for m2_block_scheduler: engine responders with programmable latency,
// a phase-list model of the schedule and a per-cycle compare process.
module tb_m2_block_scheduler;

    logic        CLOCK_50_I = 1'b0;
    logic        Resetn = 1'b0;
    logic        m2_start = 1'b0;
    logic        m2_finish, busy;
    logic        fetch_start, ct_start, cs_start, ws_start;
    logic        fetch_done, ct_done, cs_done, ws_done;
    logic [17:0] fetch_base, write_base;
    logic [1:0]  fetch_seg, write_seg;

    logic [3:0]  rsp = '0;
    logic [3:0]  stray = '0;
    int          lat_f = 1, lat_ct = 1, lat_cs = 1, lat_w = 1;
    bit          skew_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_f = 0, n_ct = 0, n_cs = 0, n_w = 0, n_fin = 0;

    assign fetch_done = rsp[3] | stray[3];
    assign ct_done    = rsp[2] | stray[2];
    assign cs_done    = rsp[1] | stray[1];
    assign ws_done    = rsp[0] | stray[0];

    m2_block_scheduler dut (
        .CLOCK_50_I  (CLOCK_50_I),
        .Resetn      (Resetn),
        .m2_start    (m2_start),
        .m2_finish   (m2_finish),
        .busy        (busy),
        .fetch_start (fetch_start),
        .fetch_done  (fetch_done),
        .fetch_base  (fetch_base),
        .fetch_seg   (fetch_seg),
        .ct_start    (ct_start),
        .ct_done     (ct_done),
        .cs_start    (cs_start),
        .cs_done     (cs_done),
        .ws_start    (ws_start),
        .ws_done     (ws_done),
        .write_base  (write_base),
        .write_seg   (write_seg)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Block index -> segment / row / column in raster order, Y then U then V
    function automatic int model_seg(input int idx);
        return (idx < 1200) ? 0 : (idx < 1800) ? 1 : 2;
    endfunction

    function automatic int model_row(input int idx);
        if (idx < 1200) return idx / 40;
        if (idx < 1800) return (idx - 1200) / 20;
        return (idx - 1800) / 20;
    endfunction

    function automatic int model_col(input int idx);
        if (idx < 1200) return idx % 40;
        if (idx < 1800) return (idx - 1200) % 20;
        return (idx - 1800) % 20;
    endfunction

    function automatic int model_fetch(input int idx);
        case (model_seg(idx))
            0:       return 76800 + model_row(idx) * 2560 + model_col(idx) * 8;
            1:       return 76800 + 76800 + model_row(idx) * 1280 + model_col(idx) * 8;
            default: return 76800 + 115200 + model_row(idx) * 1280 + model_col(idx) * 8;
        endcase
    endfunction

    function automatic int model_write(input int idx);
        case (model_seg(idx))
            0:       return model_row(idx) * 1280 + model_col(idx) * 4;
            1:       return 38400 + model_row(idx) * 640 + model_col(idx) * 4;
            default: return 57600 + model_row(idx) * 640 + model_col(idx) * 4;
        endcase
    endfunction

    function automatic int pin_fetch(input int idx);
        case (idx)
            0:       return 76800;
            1:       return 76808;
            40:      return 79360;
            1200:    return 153600;
            1800:    return 192000;
            2399:    return 229272;
            default: return -1;
        endcase
    endfunction

    function automatic int pin_write(input int idx);
        case (idx)
            0:       return 0;
            1:       return 4;
            40:      return 1280;
            1200:    return 38400;
            1800:    return 57600;
            2399:    return 76236;
            default: return -1;
        endcase
    endfunction

    // Phase k of a run: {F},{CT}, then 2399 pairs of {CS,F},{CT,W}, then {CS},{W}; 4802 is m2_finish
    function automatic logic [3:0] phase_set(input int k);
        if (k == 0) return 4'b1000;
        if (k == 1) return 4'b0100;
        if (k == 4800) return 4'b0010;
        if (k == 4801) return 4'b0001;
        if (k >= 4802) return 4'b0000;
        return (k % 2 == 0) ? 4'b1010 : 4'b0101;
    endfunction

    function automatic bit skew_fetch(input logic [17:0] b);
        return (b == 18'd76840) || (b == 18'd76848) || (b == 18'd76856);
    endfunction

    // Engine responders: done rises lat cycles after the start pulse
    initial begin
        int cnt[4];
        logic [3:0] sv;
        for (int e = 0; e < 4; e++) cnt[e] = 0;
        forever begin
            @(posedge CLOCK_50_I);
            #2;
            rsp = '0;
            sv  = {fetch_start, ct_start, cs_start, ws_start};
            for (int e = 0; e < 4; e++) begin
                if (!Resetn) begin
                    cnt[e] = 0;
                end else begin
                    if (cnt[e] > 0) begin
                        cnt[e]--;
                        if (cnt[e] == 0) rsp[e] = 1'b1;
                    end
                    if (sv[e]) begin
                        case (e)
                            3:       cnt[e] = (skew_en && skew_fetch(fetch_base)) ? 50 : lat_f;
                            2:       cnt[e] = lat_ct;
                            1:       cnt[e] = (skew_en && fetch_start && skew_fetch(fetch_base)) ? 3 : lat_cs;
                            default: cnt[e] = lat_w;
                        endcase
                    end
                end
            end
        end
    end

    // Compare process: checks every output on every falling edge
    initial begin
        int k, nxt_cyc, busy_from, fidx, widx;
        bit run, waiting, was_run, phase_now;
        logic [3:0] req, got, exp_vec;
        logic [17:0] hold_f, hold_w;
        logic [1:0] hold_fs, hold_ws;
        k = 0; nxt_cyc = 0; busy_from = 0; fidx = 0; widx = 0;
        run = 0; waiting = 0; req = '0; got = '0;
        hold_f = '0; hold_w = '0; hold_fs = '0; hold_ws = '0;
        forever begin
            @(negedge CLOCK_50_I);
            cyc++;
            if (!Resetn) begin
                chk("reset_ctrl", 32'({m2_finish, busy, fetch_start, ct_start, cs_start, ws_start}), 32'd0);
                chk("reset_fetch", 32'({fetch_seg, fetch_base}), 32'd0);
                chk("reset_write", 32'({write_seg, write_base}), 32'd0);
                run = 0; waiting = 0; k = 0; fidx = 0; widx = 0;
                hold_f = '0; hold_w = '0; hold_fs = '0; hold_ws = '0;
            end else begin
                was_run   = run;
                phase_now = run && !waiting && (cyc == nxt_cyc);
                exp_vec   = phase_now ? phase_set(k) : 4'b0000;
                chk("start_vec", 32'({fetch_start, ct_start, cs_start, ws_start}), 32'(exp_vec));
                chk("m2_finish", 32'(m2_finish), 32'(phase_now && k == 4802));
                chk("busy", 32'(busy), 32'(run && cyc >= busy_from));
                if (fetch_start) begin
                    hold_f  = 18'(model_fetch(fidx));
                    hold_fs = 2'(model_seg(fidx));
                    if (pin_fetch(fidx) >= 0) chk("fetch_base_pin", 32'(fetch_base), pin_fetch(fidx));
                    fidx++;
                    n_f++;
                end
                if (ws_start) begin
                    hold_w  = 18'(model_write(widx));
                    hold_ws = 2'(model_seg(widx));
                    if (pin_write(widx) >= 0) chk("write_base_pin", 32'(write_base), pin_write(widx));
                    widx++;
                    n_w++;
                end
                chk("fetch_addr", 32'({fetch_seg, fetch_base}), 32'({hold_fs, hold_f}));
                chk("write_addr", 32'({write_seg, write_base}), 32'({hold_ws, hold_w}));
                if (ct_start) n_ct++;
                if (cs_start) n_cs++;
                if (m2_finish) n_fin++;
                if (phase_now) begin
                    if (k == 4802) begin
                        run = 0;
                    end else begin
                        req     = phase_set(k);
                        got     = '0;
                        waiting = 1;
                    end
                end else if (waiting) begin
                    got = got | ({fetch_done, ct_done, cs_done, ws_done} & req);
                    if (got == req) begin
                        waiting = 0;
                        k++;
                        nxt_cyc = cyc + 1;
                    end
                end
                if (m2_start && !was_run) begin
                    run = 1; waiting = 0; k = 0;
                    nxt_cyc = cyc + 1; busy_from = cyc + 1;
                    fidx = 0; widx = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50_I);
            #1;
        end
    endtask

    task automatic pulse_start();
        m2_start = 1'b1;
        step(1);
        m2_start = 1'b0;
    endtask

    task automatic wait_finish(input int limit, input string name);
        int seen;
        int i;
        seen = n_fin;
        i = 0;
        while (n_fin == seen && i < limit) begin
            step(1);
            i++;
        end
        chk(name, 32'(n_fin != seen), 32'd1);
    endtask

    task automatic run_counts(input string name, input int f0, input int ct0, input int cs0,
                              input int w0, input int fin0);
        chk({name, "_fetch_pulses"}, n_f - f0, 2400);
        chk({name, "_ct_pulses"}, n_ct - ct0, 2400);
        chk({name, "_cs_pulses"}, n_cs - cs0, 2400);
        chk({name, "_ws_pulses"}, n_w - w0, 2400);
        chk({name, "_finish_pulses"}, n_fin - fin0, 1);
    endtask

    initial begin
        int f0, ct0, cs0, w0, fin0;
        Resetn = 1'b0;
        step(3);
        Resetn = 1'b1;
        step(4);

        // Dones with nothing outstanding must not advance anything
        stray = 4'b1111;
        step(1);
        stray = 4'b0000;
        step(3);

        // Run 1: one-cycle responders, a second m2_start while busy
        f0 = n_f; ct0 = n_ct; cs0 = n_cs; w0 = n_w; fin0 = n_fin;
        pulse_start();
        step(100);
        pulse_start();
        wait_finish(30000, "run1_finish");
        step(3);
        run_counts("run1", f0, ct0, cs0, w0, fin0);

        // Run 2: skewed dones, then reset in mid-run
        lat_f = 2; lat_ct = 1; lat_cs = 1; lat_w = 3; skew_en = 1'b1;
        pulse_start();
        step(600);
        Resetn = 1'b0;
        step(3);
        Resetn = 1'b1;
        step(5);

        // Run 3: mixed latencies with skew, full frame after reset
        lat_f = 1; lat_ct = 2; lat_cs = 3; lat_w = 1;
        f0 = n_f; ct0 = n_ct; cs0 = n_cs; w0 = n_w; fin0 = n_fin;
        pulse_start();
        wait_finish(40000, "run3_finish");
        step(3);
        run_counts("run3", f0, ct0, cs0, w0, fin0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
